// File: rtl/signed_division_sequencer.sv
// ---------------------------------------------------------------------------
// signed_division_sequencer
//
// Purpose
//   Iterative DIV/REM engine for the multiply-divide unit. It produces one
//   quotient bit per cycle with a restoring algorithm on operand magnitudes,
//   then applies the two's-complement sign fix-up. Divide-by-zero and the
//   signed overflow case (-2^(WIDTH-1) / -1) return fixed architected results.
//
// Optional feature
//   DIV_SPECIAL_CASE_BYPASS_EN : when defined, divide-by-zero and overflow
//   operations go straight from IDLE to DONE (result valid after the
//   handshake edge). When undefined, every operation takes the full
//   CALC/FIX path.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  engine can accept operands
//   is_signed  in   1 = DIV/REM, 0 = DIVU/REMU
//   dividend   in   WIDTH-bit dividend
//   divisor    in   WIDTH-bit divisor
//   out_valid  out  quotient/remainder valid
//   out_ready  in   consumer accepts result
//   quotient   out  quotient, truncated toward zero
//   remainder  out  remainder, sign follows dividend
//   ovf        out  signed overflow case taken
//   dbz        out  divide-by-zero case taken
// ---------------------------------------------------------------------------

// Flags the one signed division whose quotient does not fit: MIN / -1.
module divisionOverflowDetectionBlock #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             overflow_o
);
    assign overflow_o = (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor_i);
endmodule

module signed_division_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ovf,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;          // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvsr_q, dvsr_d;        // divisor magnitude
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             signed_q, signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             ovf_out_q, ovf_out_d;
    logic             dbz_out_q, dbz_out_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             det_ovf;
    logic             ovf_now;
    logic             dbz_now;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    divisionOverflowDetectionBlock #(.WIDTH(WIDTH)) u_ovf_det (
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .overflow_o (det_ovf)
    );

    assign dbz_now = (divisor == '0);
    assign ovf_now = is_signed & det_ovf;

    // Magnitudes; MIN maps to itself, which reads correctly as unsigned.
    assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Trial subtract on WIDTH+1 bits with an extra sign bit so it never wraps.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dividend_d  = dividend_q;
        signed_d    = signed_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_out_d   = ovf_out_q;
        dbz_out_d   = dbz_out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = CALC;
                    cnt_d      = CW'(WIDTH-1);
                    rem_d      = '0;
                    quo_d      = dividend_mag;
                    dvsr_d     = divisor_mag;
                    dividend_d = dividend;
                    signed_d   = is_signed;
                    q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_d    = dividend[WIDTH-1];
                    dbz_d      = dbz_now;
                    ovf_d      = ovf_now & ~dbz_now;
`ifdef DIV_SPECIAL_CASE_BYPASS_EN
                    if (dbz_now || ovf_now) begin
                        state_d     = DONE;
                        quotient_d  = dbz_now ? '1 : dividend;
                        remainder_d = dbz_now ? dividend : '0;
                        dbz_out_d   = dbz_now;
                        ovf_out_d   = ovf_now & ~dbz_now;
                        out_valid_d = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                // diff MSB set means the trial subtraction went negative: restore.
                rem_d = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                quotient_d  = (signed_q && q_neg_q) ? -quo_q : quo_q;
                remainder_d = (signed_q && r_neg_q) ? -rem_q : rem_q;
                ovf_out_d   = 1'b0;
                dbz_out_d   = 1'b0;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_out_d   = 1'b1;
                end else if (ovf_q) begin
                    quotient_d  = dividend_q;
                    remainder_d = '0;
                    ovf_out_d   = 1'b1;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so it stays low for the first cycle after reset release.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dividend_q  <= '0;
            signed_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_out_q   <= 1'b0;
            dbz_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dividend_q  <= dividend_d;
            signed_q    <= signed_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_out_q   <= ovf_out_d;
            dbz_out_q   <= dbz_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_out_q;
    assign dbz       = dbz_out_q;
endmodule

// File: tb/tb_signed_division_sequencer.sv
// ---------------------------------------------------------------------------
// tb_signed_division_sequencer
//
// Self-checking bench for signed_division_sequencer (WIDTH=32). Expected
// results come from a behavioural model using the language's own / and %
// operators plus the architected special cases; they are queued when an
// operation is issued and popped when the engine presents its result.
// ---------------------------------------------------------------------------
module tb_signed_division_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ovf;
    logic         dbz;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         o;
        logic         z;
    } exp_t;

    exp_t sb[$];

    signed_division_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        sa  = a;
        sbv = b;
        e.o = 1'b0;
        e.z = 1'b0;
        if (b == 0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.o = 1'b1;
        end else if (sg) begin
            e.q = sa / sbv; e.r = sa % sbv;
        end else begin
            e.q = a / b; e.r = a % b;
        end
        return e;
    endfunction

    function automatic int exp_latency(input exp_t e);
`ifdef DIV_SPECIAL_CASE_BYPASS_EN
        if (e.o || e.z) return 0;
`endif
        return W + 1;
    endfunction

    // Drive one operation from a negedge, push its expectation, and return
    // just after the handshake edge (edge 0). ok=0 if in_ready never rose.
    task automatic send(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int hs_cyc, output bit ok);
        ok = 1'b0;
        hs_cyc = -1;
        @(negedge clk);
        is_signed = sg; dividend = a; divisor = b; in_valid = 1'b1;
        sb.push_back(model(sg, a, b));
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                hs_cyc = cyc;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Edge index (0 = handshake edge) after which out_valid was first seen.
    task automatic wait_out(output int idx);
        idx = 0;
        @(negedge clk);
        while (!out_valid && idx < 100) begin
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, ovf, dbz, quotient, remainder} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b ovf=%b dbz=%b q=%h r=%h want all zero",
                     in_ready, out_valid, ovf, dbz, quotient, remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic         sg_t[14];
        logic [W-1:0] a_t[14];
        logic [W-1:0] b_t[14];
        int hs, idx;
        bit ok;
        exp_t e;
        sg_t = '{1, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
        a_t  = '{32'd100, -32'sd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                 32'd7, -32'sd100, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        b_t  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF,
                 -32'sd2, -32'sd7, 32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 10; i < 14; i++) begin
            a_t[i] = $urandom;
            b_t[i] = $urandom_range(1, 100000);
            if (i[0]) b_t[i] = -b_t[i];
        end
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(sg_t[i], a_t[i], b_t[i], hs, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL basic_handshake op=%0d got no in_ready want handshake", i);
                sb.delete();
                continue;
            end
            wait_out(idx);
            e = sb.pop_front();
            total++;
            if (idx !== exp_latency(e)) begin
                bad++;
                $display("FAIL basic_latency op=%0d got %0d want %0d", i, idx, exp_latency(e));
            end
            total++;
            if ({quotient, remainder, ovf, dbz} !== {e.q, e.r, e.o, e.z}) begin
                bad++;
                $display("FAIL basic_result op=%0d got q=%h r=%h ovf=%b dbz=%b want q=%h r=%h ovf=%b dbz=%b",
                         i, quotient, remainder, ovf, dbz, e.q, e.r, e.o, e.z);
            end
            $display("op %0d sg=%b %h / %h -> q=%h r=%h ovf=%b dbz=%b lat=%0d",
                     i, sg_t[i], a_t[i], b_t[i], quotient, remainder, ovf, dbz, idx);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_release op=%0d got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int hs, idx;
        bit ok;
        exp_t e;
        out_ready = 1'b0;
        send(1'b1, 32'd1000, -32'sd3, hs, ok);
        wait_out(idx);
        total++;
        if (!ok || sb.size() != 1) begin
            bad++;
            $display("FAIL hold_setup got ok=%b queued=%0d want ok=1 queued=1", ok, sb.size());
            sb.delete();
            return;
        end
        e = sb.pop_front();
        // A competing request while the result is parked must be ignored.
        is_signed = 1'b0; dividend = 32'd77; divisor = 32'd11; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, quotient, remainder, ovf, dbz} !== {1'b1, 1'b0, e.q, e.r, e.o, e.z}) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=%h r=%h",
                         i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_ignored_req got vld=%b want 0", out_valid);
        end
        $display("hold: q=%h r=%h held 10 cycles", e.q, e.r);
    endtask

    task automatic test_back_to_back();
        int hs, prev, idx;
        bit ok;
        exp_t e;
        logic [W-1:0] a, b;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 5000);
            send(1'b1, a, b, hs, ok);
            wait_out(idx);
            e = sb.pop_front();
            total++;
            if (!ok || {quotient, remainder, ovf, dbz} !== {e.q, e.r, e.o, e.z}) begin
                bad++;
                $display("FAIL b2b_result op=%0d got q=%h r=%h want q=%h r=%h", i, quotient, remainder, e.q, e.r);
            end
            if (i > 0) begin
                total++;
                if (hs - prev !== W + 3) begin
                    bad++;
                    $display("FAIL b2b_interval op=%0d got %0d want %0d", i, hs - prev, W + 3);
                end
            end
            $display("b2b %0d %h / %h -> q=%h r=%h interval=%0d", i, a, b, quotient, remainder, hs - prev);
            prev = hs;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int hs, idx;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        send(1'b1, 32'd123456, 32'd789, hs, ok);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== '0) begin
            bad++;
            $display("FAIL midreset_abort got vld=%b rdy=%b q=%h want vld=0 rdy=0 q=0", out_valid, in_ready, quotient);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_recover got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        send(1'b1, 32'd9, 32'd3, hs, ok);
        wait_out(idx);
        e = sb.pop_front();
        total++;
        if (!ok || idx !== W + 1 || {quotient, remainder, ovf, dbz} !== {e.q, e.r, e.o, e.z}) begin
            bad++;
            $display("FAIL midreset_next got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                     quotient, remainder, idx, e.q, e.r, W + 1);
        end
        $display("after reset 9/3 -> q=%h r=%h", quotient, remainder);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
